// File: rtl/mult16_pkg.sv
// mult16 shared definitions.
// State encoding, operand width and loop bound.
package mult16_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'd15;

endpackage

// File: rtl/mult16_if.sv
// mult16 start/busy/done handshake bundle.
// Master issues operands, slave returns product.
interface mult16_if
  import mult16_pkg::*;
();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/add16c.sv
// 16-bit ripple adder with carry-out.
// Result is 17 bits, zero-extended operands.
module add16c (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [16:0] o_sum
);

  logic [16:0] w_c;
  logic [15:0] w_s;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    fa1 u_fa (
      .i_a  (i_a[i]),
      .i_b  (i_b[i]),
      .i_ci (w_c[i]),
      .o_s  (w_s[i]),
      .o_co (w_c[i+1])
    );
  end

  // carry-out forms the top sum bit
  assign o_sum = {w_c[16], w_s};

endmodule

// File: rtl/and16.sv
// 16-bit bitwise AND stage.
// Used to gate the multiplicand into a partial product.
module and16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);

  // bitwise gating
  assign o_y = i_a & i_b;

endmodule

// File: rtl/fa1.sv
// Single-bit full-adder cell.
// Building block of the ripple adder.
module fa1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  // sum and carry
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/mult16.sv
// Sequential 16x16 unsigned shift-and-add multiplier.
// One partial product per cycle, 17 cycles per result.
module mult16
  import mult16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mult16_if.slave  bus
);

  if (WIDTH != mult16_pkg::WIDTH) begin : g_bad_width
    $error("mult16: WIDTH must be 16 to match and16");
  end

  state_t      r_state;
  logic [15:0] r_mcand;
  logic [16:0] r_hi;
  logic [15:0] r_lo;
  logic [3:0]  r_cnt;
  logic [31:0] r_p;

  logic [15:0] w_pp;
  logic [16:0] w_sum;
  logic [32:0] w_shift;
  logic        w_unused;

  and16 u_and (
    .i_a (r_mcand),
    .i_b ({16{r_lo[0]}}),
    .o_y (w_pp)
  );

  add16c u_add (
    .i_a   (r_hi[15:0]),
    .i_b   (w_pp),
    .o_sum (w_sum)
  );

  // {sum, lo} shifted right by one
  assign w_shift = {1'b0, w_sum, r_lo[15:1]};

  // hi[16] only ever holds the shifted-in zero
  assign w_unused = r_hi[16];

  // FSM, counter, shift register and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_mcand <= bus.a;
            r_lo    <= bus.b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_hi  <= w_shift[32:16];
          r_lo  <= w_shift[15:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == CNT_LAST) begin
            r_p     <= w_shift[31:0];
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.p    = r_p;

endmodule
